// File: rtl/ethernet_icmp_rx_classifier.sv
// Receive-side classifier for ICMP echo requests on a 64-bit Ethernet/IPv4 beat stream.
// Optional build macro ICMP_REPLY_TYPE_EN: part1 uses a zero type byte (echo-reply checksum).
module ethernet_icmp_rx_classifier #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_0A
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [63:0] i_rx_axis_tdata,
    input  logic        i_rx_axis_tvalid,
    input  logic        i_rx_axis_tlast,
    input  logic [7:0]  i_rx_axis_tkeep,
    output logic        o_icmp_valid,
    output logic [20:0] o_icmp_crc_part1,
    output logic        o_icmp_crc_part1_ready,
    output logic [47:0] o_src_mac,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_echo_req_cnt
);

    typedef enum logic [2:0] {StIdle, StHdr, StPayload, StFlush, StDrop} state_e;

    state_e      state_q, state_d;
    logic [2:0]  beat_cnt_q;
    logic        skip_q;
    logic        valid_q;
    logic        ready_q;
    logic [20:0] part1_q;
    logic [47:0] src_mac_q;
    logic [31:0] src_ip_q;
    logic [15:0] echo_cnt_q;

    logic [7:0]  b [8];
    logic        beat_fire;
    logic        hdr_phase;
    logic        hdr_ok;
    logic        keep_partial;
    logic        early_end;
    logic        accept4;
    logic [15:0] type_word;
    logic [20:0] part1_d;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            b[i] = i_rx_axis_tdata[8*i +: 8];
        end
    end

    // skip_q marks the remainder of a frame that was cut by reset
    assign beat_fire    = i_rx_axis_tvalid && !skip_q;
    assign hdr_phase    = beat_fire && (state_q == StIdle || state_q == StHdr);
    assign keep_partial = ~&i_rx_axis_tkeep;
    assign early_end    = i_rx_axis_tlast && (keep_partial || beat_cnt_q <= 3'd4);

    always_comb begin
        hdr_ok = 1'b0;
        case (beat_cnt_q)
            3'd0: hdr_ok = ({b[0], b[1], b[2], b[3], b[4], b[5]} == LOCAL_MAC) ||
                           ({b[0], b[1], b[2], b[3], b[4], b[5]} == 48'hFFFF_FFFF_FFFF);
            3'd1: hdr_ok = ({b[4], b[5]} == 16'h0800) && (b[6] == 8'h45);
            3'd2: hdr_ok = (b[7] == 8'h01);
            3'd3: hdr_ok = ({b[6], b[7]} == LOCAL_IP[31:16]);
            3'd4: hdr_ok = ({b[0], b[1]} == LOCAL_IP[15:0]) && (b[2] == 8'h08) &&
                           (b[3] == 8'h00);
            default: hdr_ok = 1'b0;
        endcase
    end

    assign accept4 = hdr_phase && hdr_ok && (beat_cnt_q == 3'd4) && !i_rx_axis_tlast;

`ifdef ICMP_REPLY_TYPE_EN
    assign type_word = {8'h00, b[3]};
`else
    assign type_word = {b[2], b[3]};
`endif
    // Checksum bytes 36..37 are skipped, i.e. counted as zero
    assign part1_d = {5'd0, type_word} + {5'd0, b[6], b[7]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StHdr: begin
                if (hdr_phase) begin
                    if (!hdr_ok || early_end) begin
                        state_d = i_rx_axis_tlast ? StIdle : StDrop;
                    end else if (beat_cnt_q == 3'd4) begin
                        state_d = StPayload;
                    end else begin
                        state_d = StHdr;
                    end
                end
            end
            StPayload: if (beat_fire && i_rx_axis_tlast) state_d = StFlush;
            StFlush:   state_d = StIdle;
            StDrop:    if (beat_fire && i_rx_axis_tlast) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= 3'd0;
            skip_q     <= i_rx_axis_tvalid && !i_rx_axis_tlast;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            part1_q    <= 21'd0;
            src_mac_q  <= 48'd0;
            src_ip_q   <= 32'd0;
            echo_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            ready_q <= accept4;
            if (skip_q && i_rx_axis_tvalid && i_rx_axis_tlast) skip_q <= 1'b0;
            if (beat_fire) begin
                if (i_rx_axis_tlast)          beat_cnt_q <= 3'd0;
                else if (beat_cnt_q != 3'd5)  beat_cnt_q <= beat_cnt_q + 3'd1;
            end
            if (accept4) part1_q <= part1_d;
            if (accept4)                   valid_q <= 1'b1;
            else if (state_q == StFlush)   valid_q <= 1'b0;
            if (ready_q) echo_cnt_q <= echo_cnt_q + 16'd1;
            if (beat_fire && beat_cnt_q == 3'd0) src_mac_q[47:32] <= {b[6], b[7]};
            if (beat_fire && beat_cnt_q == 3'd1) src_mac_q[31:0]  <= {b[0], b[1], b[2], b[3]};
            if (beat_fire && beat_cnt_q == 3'd3) src_ip_q         <= {b[2], b[3], b[4], b[5]};
        end
    end

    assign o_icmp_valid           = valid_q;
    assign o_icmp_crc_part1       = part1_q;
    assign o_icmp_crc_part1_ready = ready_q;
    assign o_src_mac              = src_mac_q;
    assign o_src_ip               = src_ip_q;
    assign o_echo_req_cnt         = echo_cnt_q;

endmodule

// File: tb/tb_ethernet_icmp_rx_classifier.sv
// Bench for ethernet_icmp_rx_classifier: byte-level frame model, directed plus random frames.
module tb_ethernet_icmp_rx_classifier;

    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LIP  = 32'hC0_A8_01_0A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        icmp_valid;
    logic [20:0] part1;
    logic        part1_ready;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] echo_cnt;

    always #5 clk = ~clk;

    ethernet_icmp_rx_classifier dut (
        .i_clk                  (clk),
        .i_reset_n              (reset_n),
        .i_rx_axis_tdata        (tdata),
        .i_rx_axis_tvalid       (tvalid),
        .i_rx_axis_tlast        (tlast),
        .i_rx_axis_tkeep        (tkeep),
        .o_icmp_valid           (icmp_valid),
        .o_icmp_crc_part1       (part1),
        .o_icmp_crc_part1_ready (part1_ready),
        .o_src_mac              (src_mac),
        .o_src_ip               (src_ip),
        .o_echo_req_cnt         (echo_cnt)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] model_cnt;
    logic [7:0]  fb [0:95];
    int          nb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_qual();
        logic [47:0] dmac;
        logic [31:0] dip;
        dmac = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
        dip  = {fb[30], fb[31], fb[32], fb[33]};
        return (nb >= 6) && (dmac == LMAC || dmac == 48'hFFFF_FFFF_FFFF) &&
               fb[12] == 8'h08 && fb[13] == 8'h00 && fb[14] == 8'h45 && fb[23] == 8'h01 &&
               dip == LIP && fb[34] == 8'h08 && fb[35] == 8'h00;
    endfunction

    // kind: 0 unicast ok, 1 broadcast ok, 2..8 one header field corrupted
    task automatic build(input int kind, input int nbeats, input logic [15:0] id,
                         input logic [15:0] seq);
        nb = nbeats;
        for (int i = 0; i < 96; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) fb[i] = LMAC[47-8*i -: 8];
        for (int i = 0; i < 4; i++) fb[30+i] = LIP[31-8*i -: 8];
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h01;
        fb[34] = 8'h08; fb[35] = 8'h00;
        fb[38] = id[15:8]; fb[39] = id[7:0]; fb[40] = seq[15:8]; fb[41] = seq[7:0];
        case (kind)
            1: for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
            2: fb[0]  = 8'h04;
            3: fb[13] = 8'h06;
            4: fb[14] = 8'h46;
            5: begin for (int i = 0; i < 6; i++) fb[i] = 8'hFF; fb[23] = 8'h11; end
            6: fb[33] = 8'h0B;
            7: fb[34] = 8'h00;
            8: fb[35] = 8'h01;
            default: ;
        endcase
    endtask

    task automatic drive_beat(input int k, input bit last, input logic [7:0] keep);
        for (int i = 0; i < 8; i++) tdata[8*i +: 8] = fb[8*k + i];
        tvalid = 1'b1;
        tlast  = last;
        tkeep  = keep;
    endtask

    // Entered and left just after a rising edge; one idle gap cycle follows the frame
    task automatic send_frame();
        bit          q;
        logic [20:0] p1;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [7:0]  keep;
        q = model_qual();
`ifdef ICMP_REPLY_TYPE_EN
        p1 = {13'd0, fb[35]} + {5'd0, fb[38], fb[39]};
`else
        p1 = {5'd0, fb[34], fb[35]} + {5'd0, fb[38], fb[39]};
`endif
        smac = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
        sip  = {fb[26], fb[27], fb[28], fb[29]};
        for (int k = 0; k < nb; k++) begin
            keep = (k == nb - 1) ? 8'($urandom) : 8'hFF;
            drive_beat(k, k == nb - 1, keep);
            @(negedge clk);
            check("part1_ready", 64'(part1_ready), 64'(q && k == 5));
            check("icmp_valid", 64'(icmp_valid), 64'(q && k >= 5));
            if (q && k == 5) check("part1", 64'(part1), 64'(p1));
            if (q && k >= 5) begin
                check("src_mac", 64'(src_mac), 64'(smac));
                check("src_ip", 64'(src_ip), 64'(sip));
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (q) model_cnt++;
        @(negedge clk);
        check("flush_valid", 64'(icmp_valid), 64'(q));
        check("gap_ready", 64'(part1_ready), 64'd0);
        check("echo_cnt", 64'(echo_cnt), 64'(model_cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; tkeep = 8'hFF;
        model_cnt = 16'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(icmp_valid), 64'd0);
        check("rst_ready", 64'(part1_ready), 64'd0);
        check("rst_part1", 64'(part1), 64'd0);
        check("rst_src_mac", 64'(src_mac), 64'd0);
        check("rst_src_ip", 64'(src_ip), 64'd0);
        check("rst_cnt", 64'(echo_cnt), 64'd0);
        @(posedge clk); #1;

        // Unicast echo request, id 0x1234 seq 0x0001
        build(0, 8, 16'h1234, 16'h0001);
        send_frame();
        // Wrong destination IP
        build(6, 7, 16'h5555, 16'h0002);
        send_frame();
        // Broadcast UDP dropped, then a valid frame after one idle cycle
        build(5, 6, 16'h0001, 16'h0003);
        send_frame();
        build(1, 6, 16'hFFFF, 16'h0004);
        send_frame();
        // Truncated: tlast on beat 4
        build(0, 5, 16'h4321, 16'h0005);
        send_frame();

        for (int n = 0; n < 40; n++) begin
            build(int'($urandom_range(0, 8)), int'($urandom_range(3, 11)),
                  16'($urandom), 16'($urandom));
            send_frame();
        end

        // Reset pulse during beat 6 of a valid frame
        build(0, 9, 16'hABCD, 16'h0006);
        for (int k = 0; k < 9; k++) begin
            drive_beat(k, k == 8, 8'hFF);
            reset_n = (k != 6);
            @(negedge clk);
            if (k == 7) begin
                check("mid_rst_valid", 64'(icmp_valid), 64'd0);
                check("mid_rst_ready", 64'(part1_ready), 64'd0);
                check("mid_rst_part1", 64'(part1), 64'd0);
                check("mid_rst_src_mac", 64'(src_mac), 64'd0);
                check("mid_rst_src_ip", 64'(src_ip), 64'd0);
                check("mid_rst_cnt", 64'(echo_cnt), 64'd0);
            end
            if (k == 8) check("skip_valid", 64'(icmp_valid), 64'd0);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        tvalid = 1'b0; tlast = 1'b0;
        model_cnt = 16'd0;
        @(negedge clk);
        check("post_rst_valid", 64'(icmp_valid), 64'd0);
        @(posedge clk); #1;
        build(0, 7, 16'h0BAD, 16'h0007);
        send_frame();

        // Counter wrap from 0xFFFF
        force dut.echo_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.echo_cnt_q;
        model_cnt = 16'hFFFF;
        @(negedge clk);
        check("preload_cnt", 64'(echo_cnt), 64'(model_cnt));
        @(posedge clk); #1;
        build(1, 8, 16'h0100, 16'h0008);
        send_frame();
        check("wrap_cnt", 64'(echo_cnt), 64'd0);

        @(negedge clk);
        check("idle_valid", 64'(icmp_valid), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
